// File: rtl/kugelblitz_pkg.sv
// kugelblitz_pkg: shared constants and helpers for the kugelblitz TX pad stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: default minimum frame length, low-N-bit keep mask, keep popcount.
package kugelblitz_pkg;

  // Only a 512-bit datapath is supported, so keep vectors are 64 bits.
  localparam int unsigned KEEP_W            = 64;
  // Ethernet minimum frame length without FCS.
  localparam int unsigned MIN_FRAME_LEN_DEF = 60;

  // Mask with the low n bits set.
  function automatic logic [KEEP_W-1:0] low_mask(input int unsigned n);
    logic [KEEP_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < KEEP_W; i++) begin
      m[i] = (i < n);
    end
    return m;
  endfunction

  // Number of set bits in a keep vector.
  function automatic int unsigned popcount(input logic [KEEP_W-1:0] k);
    int unsigned cnt;
    cnt = 0;
    for (int unsigned i = 0; i < KEEP_W; i++) begin
      if (k[i]) begin
        cnt++;
      end
    end
    return cnt;
  endfunction

endpackage

// File: rtl/kugelblitz_axis_skid.sv
// kugelblitz_axis_skid: generic two-register valid/ready skid buffer.
// Latency: 1 cycle from input accept to m_valid_o; 1 beat/cycle while m_ready_i=1.
// Backpressure: s_ready_o is registered (= NOT temp valid); one extra beat is absorbed on a stall.
// Ports: clk_i, rst_i (sync, active-high); s_valid_i/s_ready_o/s_data_i in;
//        m_valid_o/m_ready_i/m_data_o out. Payload width set by WIDTH.
module kugelblitz_axis_skid #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic [WIDTH-1:0] s_data_i,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [WIDTH-1:0] m_data_o
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic             tmp_valid_q, tmp_valid_d;
  logic [WIDTH-1:0] tmp_data_q,  tmp_data_d;
  logic             ready_q,     ready_d;

  logic accept;
  logic out_free;

  assign accept   = s_valid_i & ready_q;
  // The output register can take a new beat if it is empty or draining now.
  assign out_free = m_ready_i | ~out_valid_q;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    tmp_valid_d = tmp_valid_q;
    tmp_data_d  = tmp_data_q;
    if (out_free) begin
      // ready_q is low whenever temp holds a beat, so accept and a
      // temp refill never coincide: temp always drains first.
      if (tmp_valid_q) begin
        out_valid_d = 1'b1;
        out_data_d  = tmp_data_q;
        tmp_valid_d = 1'b0;
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_data_d  = s_data_i;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      tmp_valid_d = 1'b1;
      tmp_data_d  = s_data_i;
    end
    ready_d = ~tmp_valid_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      tmp_valid_q <= 1'b0;
      tmp_data_q  <= '0;
      ready_q     <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      tmp_valid_q <= tmp_valid_d;
      tmp_data_q  <= tmp_data_d;
      ready_q     <= ready_d;
    end
  end

  assign s_ready_o = ready_q;
  assign m_valid_o = out_valid_q;
  assign m_data_o  = out_data_q;

endmodule

// File: rtl/kugelblitz_tx_pad.sv
// kugelblitz_tx_pad: pads short single-beat frames to MIN_FRAME_LEN with zeros, zeroes unkept bytes.
// Latency: 1 cycle input accept to m_axis_tvalid; 1 beat/cycle while m_axis_tready=1.
// Backpressure: registered s_axis_tready via skid buffer; at most one extra beat absorbed on stall.
// Ports: clk, rst (sync, active-high); s_axis_* AXI-Stream in; m_axis_* AXI-Stream out;
//        stat_frame_count / stat_pad_count exist only when KUGELBLITZ_TX_PAD_STATS_EN is defined.
module kugelblitz_tx_pad
  import kugelblitz_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 512,
  parameter int unsigned KEEP_WIDTH    = DATA_WIDTH / 8,
  parameter int unsigned USER_WIDTH    = 1,
  parameter int unsigned MIN_FRAME_LEN = MIN_FRAME_LEN_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser
`ifdef KUGELBLITZ_TX_PAD_STATS_EN
  ,
  output logic [31:0]           stat_frame_count,
  output logic [31:0]           stat_pad_count
`endif
);

  if (DATA_WIDTH != 512) begin : g_bad_data_width
    $error("kugelblitz_tx_pad: DATA_WIDTH must be 512");
  end
  if (KEEP_WIDTH * 8 != DATA_WIDTH) begin : g_bad_keep_width
    $error("kugelblitz_tx_pad: KEEP_WIDTH*8 must equal DATA_WIDTH");
  end
  if (MIN_FRAME_LEN > KEEP_WIDTH) begin : g_bad_min_len
    $error("kugelblitz_tx_pad: MIN_FRAME_LEN must not exceed KEEP_WIDTH");
  end

`ifdef KUGELBLITZ_TX_PAD_STATS_EN
  localparam int unsigned FLAG_W = 1;
`else
  localparam int unsigned FLAG_W = 0;
`endif
  localparam int unsigned PW = DATA_WIDTH + KEEP_WIDTH + 1 + USER_WIDTH + FLAG_W;

  logic                  first_beat_q, first_beat_d;
  logic                  accept;
  logic                  pad;
  logic [DATA_WIDTH-1:0] data_masked;
  logic [KEEP_WIDTH-1:0] keep_out;
  logic [PW-1:0]         skid_in;
  logic [PW-1:0]         skid_out;

  assign accept = s_axis_tvalid & s_axis_tready;

  // Acceptance is implied for the payload (only accepted beats enter the
  // buffer), so pad is evaluated without it; first_beat only moves on accept.
  assign pad = first_beat_q & s_axis_tlast &
               (popcount(s_axis_tkeep) < MIN_FRAME_LEN);

  // Unkept bytes are zeroed first; padded bytes sit above the keep boundary
  // and are therefore already zero.
  always_comb begin
    data_masked = '0;
    for (int k = 0; k < int'(KEEP_WIDTH); k++) begin
      data_masked[k*8 +: 8] = s_axis_tkeep[k] ? s_axis_tdata[k*8 +: 8] : 8'h00;
    end
  end

  assign keep_out = s_axis_tkeep | (pad ? low_mask(MIN_FRAME_LEN) : '0);

  always_comb begin
    first_beat_d = first_beat_q;
    if (accept) begin
      first_beat_d = s_axis_tlast;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      first_beat_q <= 1'b1;
    end else begin
      first_beat_q <= first_beat_d;
    end
  end

`ifdef KUGELBLITZ_TX_PAD_STATS_EN
  logic out_pad;
  assign skid_in = {data_masked, keep_out, s_axis_tlast, s_axis_tuser, pad};
  assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser, out_pad} = skid_out;
`else
  assign skid_in = {data_masked, keep_out, s_axis_tlast, s_axis_tuser};
  assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser} = skid_out;
`endif

  kugelblitz_axis_skid #(
    .WIDTH (PW)
  ) u_skid (
    .clk_i     (clk),
    .rst_i     (rst),
    .s_valid_i (s_axis_tvalid),
    .s_ready_o (s_axis_tready),
    .s_data_i  (skid_in),
    .m_valid_o (m_axis_tvalid),
    .m_ready_i (m_axis_tready),
    .m_data_o  (skid_out)
  );

`ifdef KUGELBLITZ_TX_PAD_STATS_EN
  logic [31:0] frame_cnt_q, frame_cnt_d;
  logic [31:0] pad_cnt_q,   pad_cnt_d;

  // Counted on the output handshake of the last beat; counters wrap.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    pad_cnt_d   = pad_cnt_q;
    if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
      frame_cnt_d = frame_cnt_q + 32'd1;
      if (out_pad) begin
        pad_cnt_d = pad_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
      pad_cnt_q   <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      pad_cnt_q   <= pad_cnt_d;
    end
  end

  assign stat_frame_count = frame_cnt_q;
  assign stat_pad_count   = pad_cnt_q;
`endif

endmodule

// File: tb/tb_kugelblitz_tx_pad.sv
// tb_kugelblitz_tx_pad: self-checking bench for kugelblitz_tx_pad.
// Latency: n/a (bench).
// Backpressure: bench drives m_axis_tready directly, including random stalls.
module tb_kugelblitz_tx_pad;

  localparam int DW   = 512;
  localparam int KW   = 64;
  localparam int MINL = 60;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_axis_tdata;
  logic [KW-1:0] s_axis_tkeep;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic [0:0]    s_axis_tuser;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic [0:0]    m_axis_tuser;
`ifdef KUGELBLITZ_TX_PAD_STATS_EN
  logic [31:0]   stat_frame_count;
  logic [31:0]   stat_pad_count;
`endif

  always #5 clk = ~clk;

  kugelblitz_tx_pad dut (
    .clk              (clk),
    .rst              (rst),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tkeep     (s_axis_tkeep),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tready    (s_axis_tready),
    .s_axis_tlast     (s_axis_tlast),
    .s_axis_tuser     (s_axis_tuser),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tkeep     (m_axis_tkeep),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tready    (m_axis_tready),
    .m_axis_tlast     (m_axis_tlast),
    .m_axis_tuser     (m_axis_tuser)
`ifdef KUGELBLITZ_TX_PAD_STATS_EN
    ,
    .stat_frame_count (stat_frame_count),
    .stat_pad_count   (stat_pad_count)
`endif
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
    logic          u;
  } beat_t;

  beat_t exp_q[$];
  int    n_vec = 0;
  int    n_err = 0;
  int    n_out = 0;
  int    n_frames_out = 0;
  int    stab_viol = 0;
  int    beat_idx = 0;
  bit    prev_stall = 0;
  beat_t prev_out;

  function automatic logic [KW-1:0] mk_keep(input int n);
    logic [KW-1:0] k;
    for (int i = 0; i < KW; i++) k[i] = (i < n);
    return k;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference model and scoreboard. A frame is padded when it is a single
  // beat (position 0 in the frame, last) carrying fewer than MINL bytes.
  always @(negedge clk) begin
    beat_t e;
    beat_t g;
    int    cnt;
    bit    pad;
    if (rst) begin
      exp_q.delete();
      beat_idx   = 0;
      prev_stall = 0;
    end else begin
      if (s_axis_tvalid && s_axis_tready) begin
        cnt = 0;
        for (int i = 0; i < KW; i++) if (s_axis_tkeep[i]) cnt++;
        pad = (beat_idx == 0) && s_axis_tlast && (cnt < MINL);
        for (int i = 0; i < KW; i++) begin
          e.k[i]       = s_axis_tkeep[i] | (pad && (i < MINL));
          e.d[i*8 +: 8] = s_axis_tkeep[i] ? s_axis_tdata[i*8 +: 8] : 8'h00;
        end
        e.l = s_axis_tlast;
        e.u = s_axis_tuser[0];
        exp_q.push_back(e);
        beat_idx = s_axis_tlast ? 0 : beat_idx + 1;
      end
      g = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser[0]};
      if (prev_stall && (g !== prev_out)) stab_viol++;
      if (m_axis_tvalid && m_axis_tready) begin
        n_vec++;
        n_out++;
        if (m_axis_tlast) n_frames_out++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL scoreboard: unexpected output beat keep=%h last=%b", m_axis_tkeep, m_axis_tlast);
        end else begin
          e = exp_q.pop_front();
          if (g !== e) begin
            n_err++;
            $display("FAIL scoreboard: got keep=%h last=%b user=%b data=%h, expected keep=%h last=%b user=%b data=%h",
                     g.k, g.l, g.u, g.d, e.k, e.l, e.u, e.d);
          end
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_out   = g;
    end
  end

  // Presents one beat and returns #1 after the edge that accepted it.
  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k,
                           input logic l, input logic u);
    int t;
    bit done;
    t = 0;
    done = 0;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tuser  = u;
    s_axis_tvalid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (s_axis_tready) done = 1;
      @(posedge clk);
      #1;
      if (!done) begin
        t++;
        if (t > 200) begin
          n_vec++;
          n_err++;
          $display("FAIL send_beat: s_axis_tready stuck low, got 0 required 1");
          done = 1;
        end
      end
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic send_frame(input int len, input logic u);
    int rem;
    rem = len;
    while (rem > KW) begin
      send_beat(rand_data(), '1, 1'b0, u);
      rem -= KW;
    end
    send_beat(rand_data(), mk_keep(rem), 1'b1, u);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d beats still pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++; if (s_axis_tready !== 1'b0) begin n_err++; $display("FAIL reset_tready: got %b required 0", s_axis_tready); end
    n_vec++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid: got %b required 0", m_axis_tvalid); end
    n_vec++; if (m_axis_tdata !== '0) begin n_err++; $display("FAIL reset_tdata: got %h required 0", m_axis_tdata); end
    n_vec++; if (m_axis_tkeep !== '0) begin n_err++; $display("FAIL reset_tkeep: got %h required 0", m_axis_tkeep); end
    n_vec++; if (m_axis_tlast !== 1'b0 || m_axis_tuser !== 1'b0) begin n_err++; $display("FAIL reset_last_user: got %b%b required 00", m_axis_tlast, m_axis_tuser); end
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_vec++; if (s_axis_tready !== 1'b1) begin n_err++; $display("FAIL reset_release_tready: got %b required 1", s_axis_tready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_short_frame();
    logic [DW-1:0] d;
    d = rand_data();
    send_beat(d, 64'h0000_03FF_FFFF_FFFF, 1'b1, 1'b0);
    @(negedge clk);
    n_vec++; if (m_axis_tvalid !== 1'b1) begin n_err++; $display("FAIL short_latency: tvalid got %b required 1", m_axis_tvalid); end
    n_vec++; if (m_axis_tkeep !== 64'h0FFF_FFFF_FFFF_FFFF) begin n_err++; $display("FAIL short_keep: got %h required 0fffffffffffffff", m_axis_tkeep); end
    n_vec++; if (m_axis_tdata[511:336] !== '0) begin n_err++; $display("FAIL short_pad_bytes: got %h required 0", m_axis_tdata[511:336]); end
    n_vec++; if (m_axis_tdata[335:0] !== d[335:0]) begin n_err++; $display("FAIL short_payload: got %h required %h", m_axis_tdata[335:0], d[335:0]); end
    wait_drain();
  endtask

  task automatic test_full_frame();
    logic [DW-1:0] d;
`ifdef KUGELBLITZ_TX_PAD_STATS_EN
    logic [31:0] pad_before;
    pad_before = stat_pad_count;
`endif
    @(posedge clk);
    #1;
    d = rand_data();
    send_beat(d, '1, 1'b1, 1'b1);
    @(negedge clk);
    n_vec++; if (m_axis_tdata !== d) begin n_err++; $display("FAIL full_data: got %h required %h", m_axis_tdata, d); end
    n_vec++; if (m_axis_tkeep !== '1 || m_axis_tuser !== 1'b1) begin n_err++; $display("FAIL full_keep_user: got %h/%b required all-ones/1", m_axis_tkeep, m_axis_tuser); end
    wait_drain();
`ifdef KUGELBLITZ_TX_PAD_STATS_EN
    n_vec++; if (stat_pad_count !== pad_before) begin n_err++; $display("FAIL full_pad_count: got %0d required %0d", stat_pad_count, pad_before); end
`endif
  endtask

  task automatic test_multi_beat();
    @(posedge clk);
    #1;
    send_beat(rand_data(), '1, 1'b0, 1'b0);
    send_beat(rand_data(), 64'h3FF, 1'b1, 1'b0);
    @(negedge clk);
    n_vec++; if (m_axis_tkeep !== 64'h3FF) begin n_err++; $display("FAIL multi_tail_keep: got %h required 3ff", m_axis_tkeep); end
    @(posedge clk);
    #1;
    send_beat(rand_data(), mk_keep(10), 1'b1, 1'b0);
    @(negedge clk);
    n_vec++; if (m_axis_tkeep !== mk_keep(MINL)) begin n_err++; $display("FAIL multi_next_pad_keep: got %h required %h", m_axis_tkeep, mk_keep(MINL)); end
    n_vec++; if (m_axis_tdata[511:80] !== '0) begin n_err++; $display("FAIL multi_next_pad_zero: got %h required 0", m_axis_tdata[511:80]); end
    wait_drain();
  endtask

  task automatic test_zero_keep();
    @(posedge clk);
    #1;
    send_beat(rand_data(), '0, 1'b1, 1'b0);
    @(negedge clk);
    n_vec++; if (m_axis_tkeep !== mk_keep(MINL)) begin n_err++; $display("FAIL zero_keep_keep: got %h required %h", m_axis_tkeep, mk_keep(MINL)); end
    n_vec++; if (m_axis_tdata !== '0) begin n_err++; $display("FAIL zero_keep_data: got %h required 0", m_axis_tdata); end
    wait_drain();
  endtask

  task automatic test_backpressure();
    int out_before;
    out_before = n_out;
    stab_viol  = 0;
    @(posedge clk);
    #1;
    fork
      begin
        for (int i = 0; i < 8; i++) send_beat(rand_data(), '1, (i == 7), 1'b0);
      end
      begin
        repeat (3) @(posedge clk);
        #1 m_axis_tready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_vec++; if (s_axis_tready !== 1'b0) begin n_err++; $display("FAIL bp_tready_fall: got %b required 0", s_axis_tready); end
        repeat (4) @(posedge clk);
        #1 m_axis_tready = 1'b1;
      end
    join
    wait_drain();
    n_vec++; if (n_out - out_before !== 8) begin n_err++; $display("FAIL bp_beat_count: got %0d required 8", n_out - out_before); end
    n_vec++; if (stab_viol !== 0) begin n_err++; $display("FAIL bp_stability: got %0d changes while stalled required 0", stab_viol); end
  endtask

  task automatic test_random_frames();
    int  frames_before;
    bit  done;
    frames_before = n_frames_out;
    done = 0;
    @(posedge clk);
    #1;
    fork
      begin
        for (int f = 0; f < 40; f++) begin
          send_frame($urandom_range(0, 200), 1'($urandom_range(0, 1)));
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 m_axis_tready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    m_axis_tready = 1'b1;
    wait_drain();
    n_vec++; if (n_frames_out - frames_before !== 40) begin n_err++; $display("FAIL random_frame_count: got %0d required 40", n_frames_out - frames_before); end
  endtask

  task automatic test_reset_mid_frame();
    @(posedge clk);
    #1;
    send_beat(rand_data(), '1, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_vec++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL midrst_tvalid: got %b required 0", m_axis_tvalid); end
    n_vec++; if (s_axis_tready !== 1'b0) begin n_err++; $display("FAIL midrst_tready_low: got %b required 0", s_axis_tready); end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_vec++; if (s_axis_tready !== 1'b1) begin n_err++; $display("FAIL midrst_tready_rise: got %b required 1", s_axis_tready); end
    @(posedge clk);
    #1;
    send_beat(rand_data(), mk_keep(20), 1'b1, 1'b0);
    @(negedge clk);
    n_vec++; if (m_axis_tkeep !== mk_keep(MINL)) begin n_err++; $display("FAIL midrst_pad_keep: got %h required %h", m_axis_tkeep, mk_keep(MINL)); end
    wait_drain();
  endtask

`ifdef KUGELBLITZ_TX_PAD_STATS_EN
  task automatic test_stats();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    send_frame(42, 1'b0);
    send_frame(64, 1'b0);
    send_frame(128, 1'b0);
    wait_drain();
    n_vec++; if (stat_frame_count !== 32'd3) begin n_err++; $display("FAIL stats_frames: got %0d required 3", stat_frame_count); end
    n_vec++; if (stat_pad_count !== 32'd1) begin n_err++; $display("FAIL stats_pads: got %0d required 1", stat_pad_count); end
    force dut.frame_cnt_q = 32'hFFFF_FFFF;
    force dut.pad_cnt_q   = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    release dut.frame_cnt_q;
    release dut.pad_cnt_q;
    send_frame(10, 1'b0);
    wait_drain();
    n_vec++; if (stat_frame_count !== 32'd0) begin n_err++; $display("FAIL stats_frame_wrap: got %h required 0", stat_frame_count); end
    n_vec++; if (stat_pad_count !== 32'd0) begin n_err++; $display("FAIL stats_pad_wrap: got %h required 0", stat_pad_count); end
  endtask
`endif

  initial begin
    rst           = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
    m_axis_tready = 1'b1;
    test_reset();
    test_short_frame();
    test_full_frame();
    test_multi_beat();
    test_zero_keep();
    test_backpressure();
    test_random_frames();
    test_reset_mid_frame();
`ifdef KUGELBLITZ_TX_PAD_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
